// File: rtl/multi_hz_counter.sv
// Multi-channel edge-rate counter. Each lane synchronises, filters and edge-detects
// one input; a shared gate tick latches every lane's count at the same time.

module multi_hz_counter_lane #(
  parameter int CNT_WIDTH   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_i,
  input  logic                 gate_tick_i,
  input  logic [1:0]           edge_mode_i,
  output logic [CNT_WIDTH-1:0] hz_o,
  output logic                 sat_o
);
  localparam int FW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          run_q, run_d;
  logic                   filt_q, filt_d, prev_q;
  logic [CNT_WIDTH-1:0]   acc_q, acc_d, hz_q, hz_d;
  logic                   ovf_q, ovf_d, sat_q, sat_d;
  logic                   sync_s, rise, fall, edge_p;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = filt_q & ~prev_q;
  assign fall   = ~filt_q & prev_q;

  // run_q counts consecutive samples that disagree with the filtered level
  always_comb begin
    run_d  = '0;
    filt_d = filt_q;
    if (sync_s != filt_q) begin
      if (run_q == FW'(FILT_CYCLES - 1)) filt_d = sync_s;
      else                               run_d  = run_q + FW'(1);
    end
  end

  always_comb begin
    case (edge_mode_i)
      2'b01:   edge_p = rise;
      2'b10:   edge_p = rise | fall;
      default: edge_p = fall;
    endcase
  end

  // An edge on the tick cycle seeds the next window instead of being dropped
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    hz_d  = hz_q;
    sat_d = sat_q;
    if (gate_tick_i) begin
      hz_d  = acc_q;
      sat_d = ovf_q;
      acc_d = CNT_WIDTH'(edge_p);
      ovf_d = 1'b0;
    end else if (edge_p) begin
      if (acc_q == '1) ovf_d = 1'b1;
      else             acc_d = acc_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      run_q  <= '0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      hz_q   <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      run_q  <= run_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      hz_q   <= hz_d;
      sat_q  <= sat_d;
    end
  end

  assign hz_o  = hz_q;
  assign sat_o = sat_q;
endmodule

module multi_hz_counter #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 10,
  parameter int GATE_CYCLES = 100000000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           sig_in,
  input  logic                          ext_gate,
  input  logic                          gate_sel,
  input  logic [1:0]                    edge_mode,
  output logic [CHANNELS*CNT_WIDTH-1:0] hz,
  output logic                          hz_valid,
  output logic [CHANNELS-1:0]           sat
);
  localparam int GW = $clog2(GATE_CYCLES);

  logic [GW-1:0] tmr_q, tmr_d;
  logic [1:0]    ext_q;
  logic          ext_prev_q, vld_q;
  logic          tick_int, tick_ext, gate_tick;

  // Internal timer free-runs even while the external gate is selected
  assign tick_int  = (tmr_q == GW'(GATE_CYCLES - 1));
  assign tmr_d     = tick_int ? '0 : tmr_q + GW'(1);
  assign tick_ext  = ext_q[1] ^ ext_prev_q;
  assign gate_tick = gate_sel ? tick_ext : tick_int;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q      <= '0;
      ext_q      <= '0;
      ext_prev_q <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      ext_q      <= {ext_q[0], ext_gate};
      ext_prev_q <= ext_q[1];
      vld_q      <= gate_tick;
    end
  end

  assign hz_valid = vld_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    multi_hz_counter_lane #(
      .CNT_WIDTH  (CNT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_i      (sig_in[i]),
      .gate_tick_i(gate_tick),
      .edge_mode_i(edge_mode),
      .hz_o       (hz[i*CNT_WIDTH +: CNT_WIDTH]),
      .sat_o      (sat[i])
    );
  end
endmodule

// File: tb/tb_multi_hz_counter.sv
// Bench for multi_hz_counter: directed windows plus random traffic, all cycles
// cross-checked against a history-based reference model.

module tb_multi_hz_counter;
  localparam int CH = 4, W = 6, GATE = 1000, SYNC = 2, FILT = 4;
  localparam int MAXC = (1 << W) - 1, HMAX = 65536;

  logic            clk = 1'b0;
  logic            rst_n, ext_gate, gate_sel, hz_valid;
  logic [CH-1:0]   sig_in, sat;
  logic [1:0]      edge_mode;
  logic [CH*W-1:0] hz;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  multi_hz_counter #(
    .CHANNELS(CH), .CNT_WIDTH(W), .GATE_CYCLES(GATE),
    .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ext_gate(ext_gate),
    .gate_sel(gate_sel), .edge_mode(edge_mode), .hz(hz),
    .hz_valid(hz_valid), .sat(sat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input and ext_gate histories indexed by cycles since reset
  logic [CH-1:0]   sh [HMAX];
  bit              eh [HMAX];
  int              idx = 0;
  bit              fl [CH];
  int              run [CH], ep [CH], acc [CH];
  logic            m_vld = 1'b0;
  logic [CH*W-1:0] m_hz = '0;
  logic [CH-1:0]   m_sat = '0;
  bit              m_tick, e2, e3, qe;
  logic [CH-1:0]   s_old;

  always @(posedge clk) begin
    if (!rst_n) begin
      idx = 0; m_vld = 1'b0; m_hz = '0; m_sat = '0;
      for (int c = 0; c < CH; c++) begin fl[c] = 0; run[c] = 0; ep[c] = 0; acc[c] = 0; end
    end else begin
      if (idx >= HMAX) begin
        $display("FAIL hist_overflow: got %0d limit %0d", idx, HMAX);
        $fatal(1);
      end
      e2     = (idx >= 2) ? eh[idx-2] : 1'b0;
      e3     = (idx >= 3) ? eh[idx-3] : 1'b0;
      m_tick = gate_sel ? (e2 != e3) : ((idx % GATE) == GATE - 1);
      s_old  = (idx >= SYNC) ? sh[idx-SYNC] : '0;
      m_vld  = m_tick;
      for (int c = 0; c < CH; c++) begin
        qe = (ep[c] == 1) ? (edge_mode == 2'b01 || edge_mode == 2'b10)
           : (ep[c] == 2) ? (edge_mode != 2'b01) : 1'b0;
        if (m_tick) begin
          m_hz[c*W +: W] = W'((acc[c] > MAXC) ? MAXC : acc[c]);
          m_sat[c]       = (acc[c] > MAXC);
          acc[c]         = int'(qe);
        end else acc[c] += int'(qe);
        ep[c] = 0;
        if (s_old[c] != fl[c]) begin
          run[c]++;
          if (run[c] == FILT) begin fl[c] = s_old[c]; run[c] = 0; ep[c] = fl[c] ? 1 : 2; end
        end else run[c] = 0;
      end
      sh[idx] = sig_in;
      eh[idx] = ext_gate;
      idx++;
    end
  end

  always @(negedge clk) begin
    chk("hz_valid", hz_valid, m_vld);
    if (m_vld || hz_valid) begin
      chk("hz", hz, m_hz);
      chk("sat", sat, m_sat);
    end
  end

  // Stimulus generators: 0 const, 1 periodic, 2 random hold, 3 three-pulse burst
  int kind [CH], per [CH], hi [CH], ph [CH], rem [CH], nb [CH];
  bit lvl [CH];
  bit ext_r = 1'b0;

  task automatic setgen(input int c, input int k, input int p, input int h, input bit l);
    kind[c] = k; per[c] = p; hi[c] = h; lvl[c] = l; ph[c] = 0; rem[c] = 0; nb[c] = 3;
  endtask

  task automatic step(input int n);
    logic [CH-1:0] v;
    repeat (n) begin
      @(negedge clk);
      v = '0;
      for (int c = 0; c < CH; c++) begin
        case (kind[c])
          1: begin v[c] = (ph[c] < hi[c]); ph[c] = (ph[c] + 1) % per[c]; end
          2: begin
            if (rem[c] == 0) begin lvl[c] = ~lvl[c]; rem[c] = int'($urandom_range(1, 30)); end
            rem[c]--;
            v[c] = lvl[c];
          end
          3: begin
            v[c] = (nb[c] > 0) && (ph[c] < 10);
            if (nb[c] > 0) begin
              ph[c]++;
              if (ph[c] == 20) begin ph[c] = 0; nb[c]--; end
            end
          end
          default: v[c] = lvl[c];
        endcase
      end
      sig_in   = v;
      ext_gate = ext_r;
    end
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    do begin step(1); n++; end while (!hz_valid && n < 3000);
    chk("vld_seen", hz_valid, 1);
  endtask

  function automatic logic [63:0] hzc(input int c);
    return 64'(hz[c*W +: W]);
  endfunction

  int n;

  initial begin
    rst_n = 1'b0; sig_in = '0; ext_gate = 1'b0; gate_sel = 1'b0; edge_mode = 2'b00;
    setgen(0, 1, 40, 20, 0);
    setgen(1, 1, 20, 3, 0);
    setgen(2, 0, 1, 0, 0);
    setgen(3, 0, 1, 0, 1);
    step(3);
    chk("rst_hz", hz, 0); chk("rst_sat", sat, 0); chk("rst_vld", hz_valid, 0);
    rst_n = 1'b1;

    wait_vld(n); wait_vld(n);
    chk("period", n, GATE);
    chk("fall_ch0", hzc(0), 25); chk("fall_sat0", sat[0], 0);
    chk("glitch3_ch1", hzc(1), 0); chk("const0_ch2", hzc(2), 0); chk("const1_ch3", hzc(3), 0);

    edge_mode = 2'b01;
    wait_vld(n); wait_vld(n);
    chk("rise_ch0", hzc(0), 25); chk("glitch3_rise", hzc(1), 0);

    setgen(1, 1, 20, 6, 0);
    wait_vld(n); wait_vld(n);
    chk("pulse6_ch1", hzc(1), 50); chk("pulse6_sat1", sat[1], 0);

    edge_mode = 2'b10;
    wait_vld(n); wait_vld(n);
    chk("both_ch0", hzc(0), 50); chk("sat_hz_ch1", hzc(1), MAXC); chk("sat_flag1", sat[1], 1);

    edge_mode = 2'b01;
    setgen(1, 0, 1, 0, 0);
    wait_vld(n);
    setgen(1, 3, 20, 10, 0);
    wait_vld(n);
    chk("post_sat_hz", hzc(1), 3); chk("post_sat_flag", sat[1], 0);

    setgen(0, 0, 1, 0, 0);
    gate_sel = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(497); ext_r = ~ext_r; step(1);
      wait_vld(n);
      chk("ext_latency", n, 3);
    end

    // Filtered rising edge on ch0 lands on the same cycle as the ext gate tick
    step(200);
    setgen(0, 0, 1, 0, 1);
    step(4); ext_r = ~ext_r; step(1);
    wait_vld(n);
    chk("coinc_cur", hzc(0), 0);
    step(496); ext_r = ~ext_r; step(1);
    wait_vld(n);
    chk("coinc_next", hzc(0), 1);

    gate_sel = 1'b0;
    setgen(0, 1, 40, 20, 0);
    wait_vld(n); wait_vld(n);
    step(600);
    rst_n = 1'b0; step(1);
    chk("midrst_hz", hz, 0); chk("midrst_sat", sat, 0); chk("midrst_vld", hz_valid, 0);
    rst_n = 1'b1;
    wait_vld(n);
    chk("rst_window", n, GATE);

    for (int c = 0; c < CH; c++) setgen(c, 2, 1, 0, 0);
    repeat (6) begin
      edge_mode = 2'($urandom_range(0, 3));
      wait_vld(n);
    end
    gate_sel = 1'b1;
    repeat (4) begin
      step(int'($urandom_range(20, 300))); ext_r = ~ext_r; step(1);
      wait_vld(n);
      chk("rand_ext_latency", n, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
